// File: rtl/seqdet_ctrl.sv
// Sequencer for the serial sequence detector: clears the detector, shifts a word in MSB-first, counts hits.
// Optional SEQDET_CTRL_FIRST_EN adds first_vld/first_idx reporting the window index of the first hit.
module seqdet_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned DET_LAT = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             det_clr,
  output logic             det_din,
  input  logic             det_dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt
`ifdef SEQDET_CTRL_FIRST_EN
  ,
  output logic             first_vld,
  output logic [CNT_W-1:0] first_idx
`endif
);

  localparam int unsigned      PIPE_W     = (DET_LAT > 0) ? DET_LAT : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_clear = 3'd1;
  localparam logic [2:0] st_shift = 3'd2;
  localparam logic [2:0] st_drain = 3'd3;
  localparam logic [2:0] st_done  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] word_q, word_nxt;
  logic [PIPE_W-1:0] pipe;
  logic             din_nxt;
  logic [CNT_W-1:0] hit_nxt;
  logic             win_c;

`ifdef SEQDET_CTRL_FIRST_EN
  logic [CNT_W-1:0] samp_idx, samp_nxt;
  logic             fvld_nxt;
  logic [CNT_W-1:0] fidx_nxt;
`endif

  // det_dout lines up with a shifted bit DET_LAT cycles after that bit left on det_din
  assign win_c = (DET_LAT == 0) ? (state == st_shift) : pipe[PIPE_W-1];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word_q;
    din_nxt   = 1'b0;
    hit_nxt   = hit_cnt;
`ifdef SEQDET_CTRL_FIRST_EN
    samp_nxt  = samp_idx;
    fvld_nxt  = first_vld;
    fidx_nxt  = first_idx;
    if (win_c) begin
      samp_nxt = samp_idx + CNT_ONE;
      if (det_dout && !first_vld) begin
        fvld_nxt = 1'b1;
        fidx_nxt = samp_idx;
      end
    end
`endif
    if (win_c && det_dout && (hit_cnt != CNT_MAX)) begin
      hit_nxt = hit_cnt + CNT_ONE;
    end

    case (state)
      st_idle: begin
        if (in_valid && in_ready) begin
          state_nxt = st_clear;
          word_nxt  = in_word;
          hit_nxt   = '0;
`ifdef SEQDET_CTRL_FIRST_EN
          samp_nxt  = '0;
          fvld_nxt  = 1'b0;
          fidx_nxt  = '0;
`endif
        end
      end
      st_clear: begin
        state_nxt = st_shift;
        idx_nxt   = '0;
        din_nxt   = word_q[WIDTH-1];
        word_nxt  = word_q << 1;
      end
      st_shift: begin
        if (idx == LAST_BIT) begin
          idx_nxt   = '0;
          state_nxt = (DET_LAT == 0) ? st_done : st_drain;
        end else begin
          idx_nxt  = idx + CNT_ONE;
          din_nxt  = word_q[WIDTH-1];
          word_nxt = word_q << 1;
        end
      end
      st_drain: begin
        if (idx == LAST_DRAIN) begin
          state_nxt = st_done;
        end else begin
          idx_nxt = idx + CNT_ONE;
        end
      end
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  // State, datapath and registered outputs; all flags derive from the next state
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= st_idle;
      idx      <= '0;
      word_q   <= '0;
      pipe     <= '0;
      in_ready <= 1'b0;
      det_clr  <= 1'b1;
      det_din  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit_cnt  <= '0;
`ifdef SEQDET_CTRL_FIRST_EN
      samp_idx  <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      word_q   <= word_nxt;
      pipe     <= PIPE_W'({pipe, (state == st_shift)});
      in_ready <= (state_nxt == st_idle);
      det_clr  <= (state_nxt == st_clear);
      det_din  <= din_nxt;
      busy     <= (state_nxt != st_idle);
      done     <= (state_nxt == st_done);
      hit_cnt  <= hit_nxt;
`ifdef SEQDET_CTRL_FIRST_EN
      samp_idx  <= samp_nxt;
      first_vld <= fvld_nxt;
      first_idx <= fidx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Scoreboard bench for seqdet_ctrl: a timeline model checks every cycle, a done monitor checks results.
// Two instances share stimulus: default CNT_W=5 and CNT_W=4 for saturation.
module tb_seqdet_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_word;

  logic       ready_a, clr_a, din_a, dout_a, busy_a, done_a;
  logic [4:0] hit_a;
  logic       ready_b, clr_b, din_b, dout_b, busy_b, done_b;
  logic [3:0] hit_b;
`ifdef SEQDET_CTRL_FIRST_EN
  logic       fv_a, fv_b;
  logic [4:0] fi_a;
  logic [3:0] fi_b;
`endif

  always #5 clk = ~clk;

  seqdet_ctrl #(.WIDTH(16), .CNT_W(5), .DET_LAT(1)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ready_a), .in_word(in_word),
    .det_clr(clr_a), .det_din(din_a), .det_dout(dout_a), .busy(busy_a), .done(done_a),
    .hit_cnt(hit_a)
`ifdef SEQDET_CTRL_FIRST_EN
    , .first_vld(fv_a), .first_idx(fi_a)
`endif
  );

  seqdet_ctrl #(.WIDTH(16), .CNT_W(4), .DET_LAT(1)) dut_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ready_b), .in_word(in_word),
    .det_clr(clr_b), .det_din(din_b), .det_dout(dout_b), .busy(busy_b), .done(done_b),
    .hit_cnt(hit_b)
`ifdef SEQDET_CTRL_FIRST_EN
    , .first_vld(fv_b), .first_idx(fi_b)
`endif
  );

  // Detector stubs: echo det_din one cycle later
  always @(posedge clk) begin
    dout_a <= din_a;
    dout_b <= din_b;
  end

  typedef struct {
    int unsigned hits;
    int unsigned hits_b;
    logic        fvld;
    int unsigned fidx;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic        clr_edge = 1'b0;
  bit          active = 1'b0;
  int unsigned acc_edge = 0;
  int unsigned acc_count = 0;
  logic [15:0] cur_word = 16'h0;
  int unsigned last_hits = 0;
  int          p = 0;
  logic        exp_ready;
  logic [4:0]  expv;
  exp_t        e;
  exp_t        got_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic exp_t model(input logic [15:0] w, input int unsigned done_cyc);
    exp_t r;
    r.hits     = $countones(w);
    r.hits_b   = (r.hits > 15) ? 15 : r.hits;
    r.fvld     = 1'b0;
    r.fidx     = 0;
    r.done_cyc = done_cyc;
    for (int i = 0; i < 16; i++) begin
      if (!r.fvld && w[15-i]) begin
        r.fvld = 1'b1;
        r.fidx = i;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    clr_edge <= clr;
  end

  // Cycle-by-cycle timeline model; also predicts accepts and feeds the scoreboard
  always @(negedge clk) begin
    exp_ready = 1'b0;
    if (!clr_edge) begin
      active    = 1'b0;
      last_hits = 0;
      sbq.delete();
      chk("reset_outputs", {27'd0, ready_a, clr_a, busy_a, done_a, din_a}, 32'b01000);
      chk("reset_hit_cnt", {27'd0, hit_a}, 0);
`ifdef SEQDET_CTRL_FIRST_EN
      chk("reset_first", {26'd0, fv_a, fi_a}, 0);
`endif
    end else if (active) begin
      p = int'(cyc - acc_edge) + 1;
      expv = {1'b0, (p == 1), 1'b1, (p == 19), ((p >= 2) && (p <= 17)) ? cur_word[17-p] : 1'b0};
      chk("busy_timeline", {27'd0, ready_a, clr_a, busy_a, done_a, din_a}, {27'd0, expv});
      if (p == 1) chk("clear_hit_cnt", {27'd0, hit_a}, 0);
      if (p >= 19) begin
        active    = 1'b0;
        e         = model(cur_word, 0);
        last_hits = e.hits;
      end
    end else begin
      exp_ready = 1'b1;
      chk("idle_outputs", {27'd0, ready_a, clr_a, busy_a, done_a, din_a}, 32'b10000);
      chk("idle_hold_hit_cnt", {27'd0, hit_a}, last_hits);
    end
    if (exp_ready && clr && in_valid) begin
      active   = 1'b1;
      acc_edge = cyc + 1;
      cur_word = in_word;
      sbq.push_back(model(in_word, cyc + 19));
      acc_count++;
    end
  end

  // Result monitor: pops an expectation whenever the DUT signals done
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        got_e = sbq.pop_front();
        chk("done_cycle", cyc, got_e.done_cyc);
        chk("hit_cnt", {27'd0, hit_a}, got_e.hits);
        chk("hit_cnt_sat4", {28'd0, hit_b}, got_e.hits_b);
        chk("done_b", {31'd0, done_b}, 1);
`ifdef SEQDET_CTRL_FIRST_EN
        chk("first_vld", {31'd0, fv_a}, {31'd0, got_e.fvld});
        chk("first_idx", {27'd0, fi_a}, got_e.fidx);
`endif
      end
    end
  end

  task automatic send(input logic [15:0] w);
    int unsigned start;
    bit ok;
    start    = acc_count;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (acc_count != start) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (!active) ok = 1'b1;
    end
    chk("idle_timeout", {31'd0, ok}, 1);
  endtask

  initial begin
    clr      = 1'b0;
    in_valid = 1'b0;
    in_word  = 16'h0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(16'hA5F0);
    in_valid = 1'b0;
    wait_idle();

    send(16'hFFFF);
    in_valid = 1'b0;
    wait_idle();

    // Held valid: second word waits out the busy period
    send(16'h0001);
    send(16'h8000);
    in_valid = 1'b0;
    wait_idle();

    send(16'h0100);
    send(16'h0000);
    in_valid = 1'b0;
    wait_idle();

    // Reset during the 6th shift cycle
    send(16'hFFFF);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 clr = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int n = 0; n < 1500; n++) begin
      clr      = ($urandom_range(199) != 0);
      in_valid = ($urandom_range(2) == 0);
      in_word  = 16'($urandom);
      if ($urandom_range(3) == 0) in_word = 16'hFFFF;
      @(posedge clk);
      #1;
    end
    clr      = 1'b1;
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
